// File: rtl/regfile_scoreboard.sv
// Register file with a per-register pending (scoreboard) bit and a registered pending count.
// Define REGFILE_BYPASS_EN to forward same-cycle write data and readiness to the read ports.
module regfile_scoreboard #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 32,
   parameter int AW    = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [AW-1:0]    rd_addr1,
   input  logic [AW-1:0]    rd_addr2,
   output logic [WIDTH-1:0] rd_data1,
   output logic [WIDTH-1:0] rd_data2,
   output logic             rd_ready1,
   output logic             rd_ready2,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             resv_en,
   input  logic [AW-1:0]    resv_addr,
   output logic [AW:0]      pend_count
);

   logic [WIDTH-1:0] r_regs [DEPTH];
   logic [DEPTH-1:0] r_pending;
   logic [AW:0]      r_pendCount;

   logic [DEPTH-1:0] w_pendNext;
   logic [AW:0]      w_popCount;
   logic             w_wrValid;
   logic             w_resvValid;
   logic [WIDTH-1:0] w_stored1;
   logic [WIDTH-1:0] w_stored2;

   assign w_wrValid   = wr_en && (wr_addr != '0);
   assign w_resvValid = resv_en && (resv_addr != '0);

   // Clear is applied before set so a same-cycle reservation keeps the register pending.
   always_comb begin
      w_pendNext = r_pending;
      if (w_wrValid)
         w_pendNext[wr_addr] = 1'b0;
      if (w_resvValid)
         w_pendNext[resv_addr] = 1'b1;
      w_pendNext[0] = 1'b0;
   end

   always_comb begin
      w_popCount = '0;
      for (int i = 0; i < DEPTH; i++)
         w_popCount = w_popCount + {{AW{1'b0}}, w_pendNext[i]};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++)
            r_regs[i] <= '0;
         r_pending   <= '0;
         r_pendCount <= '0;
      end else begin
         if (w_wrValid)
            r_regs[wr_addr] <= wr_data;
         r_pending   <= w_pendNext;
         r_pendCount <= w_popCount;
      end
   end

   assign w_stored1  = (rd_addr1 == '0) ? '0 : r_regs[rd_addr1];
   assign w_stored2  = (rd_addr2 == '0) ? '0 : r_regs[rd_addr2];
   assign pend_count = r_pendCount;

`ifdef REGFILE_BYPASS_EN
   logic w_fwd1;
   logic w_fwd2;
   logic w_resvOnWr;

   // A write that is re-reserved in the same cycle still forwards data but stays not-ready.
   assign w_resvOnWr = w_resvValid && (resv_addr == wr_addr);
   assign w_fwd1     = w_wrValid && (wr_addr == rd_addr1);
   assign w_fwd2     = w_wrValid && (wr_addr == rd_addr2);

   assign rd_data1  = w_fwd1 ? wr_data : w_stored1;
   assign rd_data2  = w_fwd2 ? wr_data : w_stored2;
   assign rd_ready1 = w_fwd1 ? ~w_resvOnWr : ~r_pending[rd_addr1];
   assign rd_ready2 = w_fwd2 ? ~w_resvOnWr : ~r_pending[rd_addr2];
`else
   assign rd_data1  = w_stored1;
   assign rd_data2  = w_stored2;
   assign rd_ready1 = ~r_pending[rd_addr1];
   assign rd_ready2 = ~r_pending[rd_addr2];
`endif

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed self-checking bench for regfile_scoreboard; expected values are hand-computed constants.
// Expectations for the same-cycle write/read case follow REGFILE_BYPASS_EN when it is defined.
module tb_regfile_scoreboard;

   localparam int WIDTH = 32;
   localparam int DEPTH = 32;
   localparam int AW    = 5;

   logic             clk;
   logic             reset;
   logic [AW-1:0]    rd_addr1;
   logic [AW-1:0]    rd_addr2;
   logic [WIDTH-1:0] rd_data1;
   logic [WIDTH-1:0] rd_data2;
   logic             rd_ready1;
   logic             rd_ready2;
   logic             wr_en;
   logic [AW-1:0]    wr_addr;
   logic [WIDTH-1:0] wr_data;
   logic             resv_en;
   logic [AW-1:0]    resv_addr;
   logic [AW:0]      pend_count;

   int assertCount;
   int failCount;

   regfile_scoreboard #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
      .clk        (clk),
      .reset      (reset),
      .rd_addr1   (rd_addr1),
      .rd_addr2   (rd_addr2),
      .rd_data1   (rd_data1),
      .rd_data2   (rd_data2),
      .rd_ready1  (rd_ready1),
      .rd_ready2  (rd_ready2),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .resv_en    (resv_en),
      .resv_addr  (resv_addr),
      .pend_count (pend_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      assertCount++;
      assert (observed === expected)
      else begin
         failCount++;
         $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
   endtask

   // Drives one clock's worth of write/reserve, then returns 1 time unit after the edge with strobes low.
   task automatic applyStimulus(input logic we, input logic [AW-1:0] wa, input logic [WIDTH-1:0] wd,
                                input logic re, input logic [AW-1:0] ra);
      wr_en     = we;
      wr_addr   = wa;
      wr_data   = wd;
      resv_en   = re;
      resv_addr = ra;
      @(posedge clk);
      #1;
      wr_en   = 1'b0;
      resv_en = 1'b0;
   endtask

   task automatic readPorts(input logic [AW-1:0] a1, input logic [AW-1:0] a2);
      rd_addr1 = a1;
      rd_addr2 = a2;
      #1;
   endtask

   initial begin
      assertCount = 0;
      failCount   = 0;
      reset     = 1'b1;
      rd_addr1  = '0;
      rd_addr2  = '0;
      wr_en     = 1'b0;
      wr_addr   = '0;
      wr_data   = '0;
      resv_en   = 1'b0;
      resv_addr = '0;

      #2;
      checkOutput("reset_pend_count", 32'(pend_count), 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;
      #1;

      for (int i = 0; i < DEPTH; i++) begin
         readPorts(AW'(i), AW'(DEPTH - 1 - i));
         checkOutput("reset_rd_data1", rd_data1, 32'd0);
         checkOutput("reset_rd_ready1", 32'(rd_ready1), 32'd1);
         checkOutput("reset_rd_data2", rd_data2, 32'd0);
         checkOutput("reset_rd_ready2", 32'(rd_ready2), 32'd1);
      end
      checkOutput("post_reset_pend_count", 32'(pend_count), 32'd0);

      applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0);
      readPorts(5'd5, 5'd0);
      checkOutput("write_r5_data", rd_data1, 32'hDEADBEEF);
      checkOutput("write_r5_ready", 32'(rd_ready1), 32'd1);

      applyStimulus(1'b1, 5'd0, 32'h00001234, 1'b0, 5'd0);
      readPorts(5'd0, 5'd0);
      checkOutput("write_r0_ignored", rd_data1, 32'd0);
      checkOutput("write_r0_pend_count", 32'(pend_count), 32'd0);

      applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd7);
      readPorts(5'd7, 5'd5);
      checkOutput("resv_r7_ready", 32'(rd_ready1), 32'd0);
      checkOutput("resv_r7_other_ready", 32'(rd_ready2), 32'd1);
      checkOutput("resv_r7_pend_count", 32'(pend_count), 32'd1);

      applyStimulus(1'b1, 5'd7, 32'h00000055, 1'b0, 5'd0);
      readPorts(5'd7, 5'd7);
      checkOutput("write_r7_ready", 32'(rd_ready1), 32'd1);
      checkOutput("write_r7_data", rd_data1, 32'h00000055);
      checkOutput("write_r7_pend_count", 32'(pend_count), 32'd0);

      applyStimulus(1'b1, 5'd3, 32'h000000A5, 1'b1, 5'd3);
      readPorts(5'd7, 5'd3);
      checkOutput("resv_wins_data", rd_data2, 32'h000000A5);
      checkOutput("resv_wins_ready", 32'(rd_ready2), 32'd0);
      checkOutput("resv_wins_pend_count", 32'(pend_count), 32'd1);

      applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd3);
      checkOutput("double_resv_pend_count", 32'(pend_count), 32'd1);

      applyStimulus(1'b1, 5'd5, 32'h00000011, 1'b0, 5'd0);
      readPorts(5'd5, 5'd3);
      checkOutput("nonpending_write_data", rd_data1, 32'h00000011);
      checkOutput("nonpending_write_ready", 32'(rd_ready1), 32'd1);
      checkOutput("nonpending_write_pend_count", 32'(pend_count), 32'd1);

      applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd0);
      readPorts(5'd0, 5'd0);
      checkOutput("resv_r0_ready", 32'(rd_ready1), 32'd1);
      checkOutput("resv_r0_pend_count", 32'(pend_count), 32'd1);

      applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd9);
      readPorts(5'd9, 5'd9);
      checkOutput("resv_r9_ready", 32'(rd_ready1), 32'd0);
      checkOutput("resv_r9_pend_count", 32'(pend_count), 32'd2);

      // Same-cycle write and read of r9 before the edge.
      wr_en   = 1'b1;
      wr_addr = 5'd9;
      wr_data = 32'h00000077;
      #1;
`ifdef REGFILE_BYPASS_EN
      checkOutput("same_cycle_data1", rd_data1, 32'h00000077);
      checkOutput("same_cycle_ready1", 32'(rd_ready1), 32'd1);
`else
      checkOutput("same_cycle_data1", rd_data1, 32'd0);
      checkOutput("same_cycle_ready1", 32'(rd_ready1), 32'd0);
`endif
      checkOutput("dual_port_data_match", rd_data2, rd_data1);
      checkOutput("dual_port_ready_match", 32'(rd_ready2), 32'(rd_ready1));
      @(posedge clk);
      #1;
      wr_en = 1'b0;
      #1;
      checkOutput("after_write_r9_data", rd_data1, 32'h00000077);
      checkOutput("after_write_r9_ready", 32'(rd_ready1), 32'd1);
      checkOutput("after_write_r9_pend_count", 32'(pend_count), 32'd1);

      for (int i = 1; i <= 15; i++)
         applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, AW'(i));
      checkOutput("resv_r1_r15_pend_count", 32'(pend_count), 32'd15);

      // Reset lands mid-cycle while a reservation of r16 is being driven.
      resv_en   = 1'b1;
      resv_addr = 5'd16;
      rd_addr1  = 5'd3;
      rd_addr2  = 5'd5;
      #1;
      reset = 1'b1;
      #1;
      checkOutput("async_reset_pend_count", 32'(pend_count), 32'd0);
      checkOutput("async_reset_ready_r3", 32'(rd_ready1), 32'd1);
      checkOutput("async_reset_data_r5", rd_data2, 32'd0);
      @(posedge clk);
      #1;
      checkOutput("reset_held_resv_ignored", 32'(pend_count), 32'd0);
      resv_en = 1'b0;
      reset   = 1'b0;
      readPorts(5'd16, 5'd9);
      checkOutput("post_reset_ready_r16", 32'(rd_ready1), 32'd1);
      checkOutput("post_reset_data_r9", rd_data2, 32'd0);

      for (int i = 16; i <= 31; i++)
         applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, AW'(i));
      checkOutput("resv_r16_r31_pend_count", 32'(pend_count), 32'd16);
      for (int i = 1; i <= 15; i++)
         applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, AW'(i));
      readPorts(5'd31, 5'd1);
      checkOutput("all_pend_count", 32'(pend_count), 32'd31);
      checkOutput("all_pend_ready_r31", 32'(rd_ready1), 32'd0);
      checkOutput("all_pend_ready_r1", 32'(rd_ready2), 32'd0);

      applyStimulus(1'b1, 5'd31, 32'hCAFEF00D, 1'b1, 5'd20);
      readPorts(5'd31, 5'd20);
      checkOutput("release_r31_pend_count", 32'(pend_count), 32'd30);
      checkOutput("release_r31_ready", 32'(rd_ready1), 32'd1);
      checkOutput("release_r31_data", rd_data1, 32'hCAFEF00D);
      checkOutput("r20_still_pending", 32'(rd_ready2), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data bits per register.
REQ-002 SHALL have parameter DEPTH, default 32, number of registers; power of two, at least 2.
REQ-003 SHALL have parameter AW, default 5, address bits; AW SHALL equal log2(DEPTH).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port rd_addr1  input  AW  read port 1 register number.
REQ-007 SHALL have port rd_addr2  input  AW  read port 2 register number.
REQ-008 SHALL have port rd_data1  output  WIDTH  read port 1 data.
REQ-009 SHALL have port rd_data2  output  WIDTH  read port 2 data.
REQ-010 SHALL have port rd_ready1  output  1  high when rd_addr1 has no pending write.
REQ-011 SHALL have port rd_ready2  output  1  high when rd_addr2 has no pending write.
REQ-012 SHALL have port wr_en  input  1  write strobe.
REQ-013 SHALL have port wr_addr  input  AW  write register number.
REQ-014 SHALL have port wr_data  input  WIDTH  write data.
REQ-015 SHALL have port resv_en  input  1  mark resv_addr as pending (result outstanding).
REQ-016 SHALL have port resv_addr  input  AW  register to reserve.
REQ-017 SHALL have port pend_count  output  AW+1  number of registers currently pending.

Function
REQ-018 SHALL read combinationally: rd_dataN = reg[rd_addrN], no clock latency.
REQ-019 SHALL write reg[wr_addr] <= wr_data on the rising edge when wr_en is high; one cycle latency to read-back.
REQ-020 SHALL hold register 0 at zero: reads return 0, writes and reservations to address 0 ignored, never pending.
REQ-021 SHALL keep one pending bit per register; resv_en sets pending[resv_addr] at the edge; wr_en clears pending[wr_addr] at the edge.
REQ-022 SHALL, when resv_en and wr_en target the same nonzero address in one cycle, store wr_data and leave the pending bit SET (reservation wins).
REQ-023 SHALL treat resv_en on an already-pending register as no change to pending or pend_count.
REQ-024 SHALL accept wr_en to a non-pending register: data written, pending unchanged.
REQ-025 SHALL drive rd_readyN = ~pending[rd_addrN], except as modified by REQ-031.
REQ-026 SHALL drive pend_count as a registered popcount of pending bits, updated the same edge as the pending bits; range 0..DEPTH-1.
REQ-027 SHALL allow both read ports to address the same register, returning identical data and ready.

Reset
REQ-028 SHALL, while reset is high, asynchronously clear all registers to 0, all pending bits to 0 and pend_count to 0.
REQ-029 SHALL ignore wr_en and resv_en while reset is high; after reset: rd_data1/2 = 0, rd_ready1/2 = 1, pend_count = 0.
REQ-030 SHALL discard a reservation or write coincident with reset assertion mid-operation; no partial update survives.

Configuration
REQ-031 SHALL, with macro REGFILE_BYPASS_EN defined, forward wr_data to rd_dataN and force rd_readyN = 1 when wr_en is high, wr_addr = rd_addrN and wr_addr != 0, unless resv_en reserves the same address that cycle (then rd_readyN = 0, data still forwarded).
REQ-032 SHALL, without REGFILE_BYPASS_EN, return the pre-edge stored value and pending status during a same-cycle write.

Verification
REQ-033 SHALL cover: reset, read all addresses -> data 0, ready 1, pend_count 0.
REQ-034 SHALL cover: write r5=0xDEADBEEF, read r5 next cycle -> 0xDEADBEEF; write r0=0x1234 -> r0 reads 0.
REQ-035 SHALL cover: resv r7 -> rd_ready 0 for r7, pend_count 1; write r7=0x55 -> ready 1, pend_count 0, data 0x55.
REQ-036 SHALL cover: same cycle resv r3 and write r3=0xA5 -> data 0xA5, r3 pending, pend_count 1.
REQ-037 SHALL cover: resv r9 pending, write r9=0x77 with rd_addr1=9 same cycle -> with REGFILE_BYPASS_EN rd_data1=0x77, ready 1; without, old value, ready 0.
REQ-038 SHALL cover: reserve r1..r31, assert reset mid-sequence -> all pending cleared, pend_count 0 asynchronously, before next edge.
